// File: rtl/bcd2bin_arbiter_pkg.sv
// Shared FSM state type and constants for the bcd2bin request arbiter.
package bcd2bin_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int         BIN_W     = 7;
  localparam int         WD_W      = 8;

  // Both nibbles must be legal decimal digits.
  function automatic logic bcd_byte_ok(input logic [7:0] b);
    return (b[7:4] <= DIGIT_MAX) && (b[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot grant on the first request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] rot;
  logic [N-1:0] grant_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot       = N'({req, req} >> ptr);
  assign grant_rot = rot & (~rot + N'(1));
  assign grant     = N'({grant_rot, grant_rot} >> (N - int'(ptr)));

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Shares one two-digit bcd2bin converter among NUM_REQ requesters with a WAIT watchdog.
// Optional build macro BCD2BIN_ARB_CHECK_EN rejects bytes with a nibble above 9 without using the converter.
module bcd2bin_arbiter
  import bcd2bin_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_bcd,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [BIN_W-1:0]     rsp_bin,
  output logic                 rsp_err,
  output logic                 conv_start,
  output logic [3:0]           conv_bcd1,
  output logic [3:0]           conv_bcd0,
  input  logic                 conv_ready,
  input  logic                 conv_done_tick,
  input  logic [BIN_W-1:0]     conv_bin
);

  localparam int                PTR_W   = $clog2(NUM_REQ);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  IDX_MAX = PTR_W'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   idx_reg, idx_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic [7:0]         bcd_reg, bcd_next;
  logic [BIN_W-1:0]   bin_reg, bin_next;
  logic               err_reg, err_next;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [7:0]         sel_bcd;
  logic [7:0]         req_byte [NUM_REQ];
  logic               handshake;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  assign req_ready = (state_reg == ST_IDLE) ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_byte[gi]  = req_bcd[8*gi +: 8];
      assign rsp_valid[gi] = (state_reg == ST_RESP) && (idx_reg == PTR_W'(gi));
    end
  endgenerate

  // Grant is one-hot, so OR-ing the set positions yields its index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = grant_idx | PTR_W'(i);
    end
  end

  assign sel_bcd = req_byte[grant_idx];

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    rr_ptr_next = rr_ptr_reg;
    wd_next     = wd_reg;
    bcd_next    = bcd_reg;
    bin_next    = bin_reg;
    err_next    = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (handshake) begin
          idx_next = grant_idx;
`ifdef BCD2BIN_ARB_CHECK_EN
          if (!bcd_byte_ok(sel_bcd)) begin
            bin_next   = '0;
            err_next   = 1'b1;
            state_next = ST_RESP;
          end else begin
            bcd_next   = sel_bcd;
            state_next = ST_ISSUE;
          end
`else
          bcd_next   = sel_bcd;
          state_next = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (conv_ready) begin
          wd_next    = '0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_next = wd_reg + WD_W'(1);
        if (conv_done_tick) begin
          bin_next   = conv_bin;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (wd_reg == WD_LAST) begin
          bin_next   = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + PTR_W'(1);
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      rr_ptr_reg <= '0;
      wd_reg     <= '0;
      bcd_reg    <= '0;
      bin_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      rr_ptr_reg <= rr_ptr_next;
      wd_reg     <= wd_next;
      bcd_reg    <= bcd_next;
      bin_reg    <= bin_next;
      err_reg    <= err_next;
    end
  end

  // The start pulse is one cycle by construction: ISSUE is left on the same edge.
  assign conv_start = (state_reg == ST_ISSUE) && conv_ready;
  assign conv_bcd1  = bcd_reg[7:4];
  assign conv_bcd0  = bcd_reg[3:0];
  assign rsp_bin    = bin_reg;
  assign rsp_err    = err_reg;

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a behavioural converter of programmable latency.
module tb_bcd2bin_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_bcd = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [6:0]  rsp_bin;
  logic        rsp_err, conv_start;
  logic [3:0]  conv_bcd1, conv_bcd0;
  logic        conv_ready, conv_done_tick;
  logic [6:0]  conv_bin;

  bcd2bin_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_bcd(req_bcd),
    .rsp_valid(rsp_valid), .rsp_bin(rsp_bin), .rsp_err(rsp_err),
    .conv_start(conv_start), .conv_bcd1(conv_bcd1), .conv_bcd0(conv_bcd0),
    .conv_ready(conv_ready), .conv_done_tick(conv_done_tick), .conv_bin(conv_bin)
  );

  always #5 clk = ~clk;

  // Converter model: done_tick 'lat' cycles after the start cycle; 'hang' withholds it.
  int         lat = 7;
  bit         hang = 1'b0;
  logic       busy;
  int         cnt;
  logic [6:0] res;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0; cnt <= 0; res <= '0;
    end else if (busy) begin
      if (cnt == 0) begin
        if (!hang) busy <= 1'b0;
      end else cnt <= cnt - 1;
    end else if (conv_start) begin
      busy <= 1'b1;
      cnt  <= lat - 1;
      res  <= 7'(conv_bcd1 * 10 + conv_bcd0);
    end
  end
  assign conv_ready     = !busy;
  assign conv_done_tick = busy && (cnt == 0) && !hang;
  assign conv_bin       = res;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         hs_idx_q[$], hs_cyc_q[$], rsp_cyc_q[$];
  logic [3:0] rsp_v_q[$];
  logic [6:0] rsp_b_q[$];
  logic       rsp_e_q[$];
  int         start_n = 0, start_cyc = 0;

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) begin
      hs_idx_q.push_back(oh2i(req_ready));
      hs_cyc_q.push_back(cyc);
    end
    if (rsp_valid != 4'b0) begin
      rsp_v_q.push_back(rsp_valid);
      rsp_b_q.push_back(rsp_bin);
      rsp_e_q.push_back(rsp_err);
      rsp_cyc_q.push_back(cyc);
    end
    if (conv_start) begin
      start_n   <= start_n + 1;
      start_cyc <= cyc;
    end
  end

  int total = 0, passed = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_idx_q.size() < target && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    req_bcd[8*idx +: 8] = b;
    req_valid[idx] = 1'b1;
    wait_hs(hs_idx_q.size() + 1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int k = 0;
    while (rsp_v_q.size() < target && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({tag, "_arrived"}, 32'(rsp_v_q.size() >= target), 32'd1);
  endtask

  task automatic chk_rsp(input string tag, input int n, input logic [3:0] v,
                         input logic [6:0] b, input logic e);
    if (rsp_v_q.size() > n) begin
      check({tag, "_valid"}, 32'(rsp_v_q[n]), 32'(v));
      check({tag, "_bin"},   32'(rsp_b_q[n]), 32'(b));
      check({tag, "_err"},   32'(rsp_e_q[n]), 32'(e));
    end
  endtask

  int         h0, r0, s0, w;
  int         pat[3]   = '{3, 0, 2};
  logic [6:0] bin_of[4] = '{7'h1e, 7'h0b, 7'h16, 7'h2f};
  int         exp_idx[4] = '{0, 1, 2, 3};
  logic [6:0] exp_bin[4] = '{7'h00, 7'h09, 7'h37, 7'h63};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_bin",   32'(rsp_bin),   32'h0);
    check("rst_rsp_err",   32'(rsp_err),   32'h0);
    check("rst_conv_start", 32'(conv_start), 32'h0);
    check("rst_conv_bcd",  32'({conv_bcd1, conv_bcd0}), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, three values, with latency checks on the first.
    r0 = rsp_v_q.size(); h0 = hs_idx_q.size();
    send(0, 8'h99); wait_rsp(r0 + 1, "t1a");
    chk_rsp("t1a", r0, 4'b0001, 7'h63, 1'b0);
    check("t1a_start_lat", 32'(start_cyc - hs_cyc_q[h0]), 32'd1);
    check("t1a_rsp_lat", 32'(rsp_cyc_q[r0] - start_cyc), 32'd8);
    send(0, 8'h55); wait_rsp(r0 + 2, "t1b");
    chk_rsp("t1b", r0 + 1, 4'b0001, 7'h37, 1'b0);
    send(0, 8'h90); wait_rsp(r0 + 3, "t1c");
    chk_rsp("t1c", r0 + 2, 4'b0001, 7'h5a, 1'b0);

    // Reset returns the pointer to 0, then four simultaneous requests.
    reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1; @(posedge clk); #1;
    h0 = hs_idx_q.size(); r0 = rsp_v_q.size();
    req_bcd = 32'h99_55_09_00; req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_hs(h0 + k + 1);
      if (hs_idx_q.size() > h0 + k) req_valid[hs_idx_q[h0 + k]] = 1'b0;
    end
    req_valid = 4'h0;
    wait_rsp(r0 + 4, "t2");
    for (int k = 0; k < 4; k++) begin
      if (hs_idx_q.size() > h0 + k) check("t2_grant", 32'(hs_idx_q[h0 + k]), 32'(exp_idx[k]));
      chk_rsp("t2", r0 + k, 4'(1 << k), exp_bin[k], 1'b0);
    end
    check("t2_grant_gap", 32'(hs_cyc_q[h0 + 1] - hs_cyc_q[h0]), 32'd10);

    // Requester 1 once, requester 2 continuously, then 0/2/3 all continuous.
    h0 = hs_idx_q.size(); r0 = rsp_v_q.size();
    req_bcd = 32'h47_22_11_30; req_valid = 4'b0110;
    wait_hs(h0 + 1); req_valid[1] = 1'b0;
    wait_hs(h0 + 2); req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    for (int k = 0; k < 20; k++) wait_hs(h0 + 3 + k);
    req_valid = 4'h0;
    wait_rsp(r0 + 22, "t3");
    check("t3_first", 32'(hs_idx_q[h0]), 32'd1);
    check("t3_second", 32'(hs_idx_q[h0 + 1]), 32'd2);
    chk_rsp("t3_r1", r0, 4'b0010, 7'h0b, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (hs_idx_q.size() > h0 + 2 + k) check("t3_rr_grant", 32'(hs_idx_q[h0 + 2 + k]), 32'(pat[k % 3]));
      if (rsp_b_q.size() > r0 + 2 + k) check("t3_rr_bin", 32'(rsp_b_q[r0 + 2 + k]), 32'(bin_of[pat[k % 3]]));
    end

    // Hung converter: timeout response, then a late tick must be ignored.
    hang = 1'b1;
    h0 = hs_idx_q.size(); r0 = rsp_v_q.size();
    send(1, 8'h12); wait_rsp(r0 + 1, "t4");
    chk_rsp("t4", r0, 4'b0010, 7'h00, 1'b1);
    check("t4_start_lat", 32'(start_cyc - hs_cyc_q[h0]), 32'd1);
    check("t4_timeout_lat", 32'(rsp_cyc_q[r0] - hs_cyc_q[h0]), 32'(TIMEOUT + 2));
    hang = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("t4_late_tick_ignored", 32'(rsp_v_q.size()), 32'(r0 + 1));

    // Asynchronous reset during WAIT aborts the transaction.
    lat = 30; s0 = start_n; w = 0;
    send(2, 8'h77);
    while (start_n == s0 && w < 100) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_req_ready", 32'(req_ready), 32'h0);
    check("t5_conv_start", 32'(conv_start), 32'h0);
    check("t5_conv_bcd", 32'({conv_bcd1, conv_bcd0}), 32'h0);
    check("t5_rsp_err", 32'(rsp_err), 32'h0);
    check("t5_rsp_bin", 32'(rsp_bin), 32'h0);
    r0 = rsp_v_q.size();
    @(posedge clk); #1 reset_n = 1'b1; lat = 7;
    repeat (40) @(posedge clk); #1;
    check("t5_no_rsp_after_abort", 32'(rsp_v_q.size()), 32'(r0));
    send(0, 8'h42); wait_rsp(r0 + 1, "t5");
    chk_rsp("t5_after", r0, 4'b0001, 7'h2a, 1'b0);

    // Illegal digit handling.
    h0 = hs_idx_q.size(); r0 = rsp_v_q.size(); s0 = start_n;
    send(3, 8'hA3); wait_rsp(r0 + 1, "t6");
`ifdef BCD2BIN_ARB_CHECK_EN
    chk_rsp("t6", r0, 4'b1000, 7'h00, 1'b1);
    check("t6_rsp_lat", 32'(rsp_cyc_q[r0] - hs_cyc_q[h0]), 32'd1);
    check("t6_no_start", 32'(start_n), 32'(s0));
`else
    chk_rsp("t6", r0, 4'b1000, 7'h67, 1'b0);
    check("t6_start_seen", 32'(start_n), 32'(s0 + 1));
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/bcd2bin_arbiter.md
# bcd2bin_arbiter

Round-robin arbiter and sequencer that shares one two-digit `bcd2bin` converter among `NUM_REQ` requesters. Accepts BCD requests over per-requester valid/ready handshakes, drives the converter's `start`/`bcd1`/`bcd0` inputs, waits for `done_tick`, and returns the 7-bit result to the winning requester tagged by a one-hot response strobe. Sits between fabric-side request logic and a single converter instance, with a watchdog so a hung converter cannot stall the requesters.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum cycles in WAIT before aborting, 2..255.
- `clk  in  1`: sole clock; all logic on its rising edge.
- `reset_n  in  1`: reset; asynchronous, active-low.
- `req_valid  in  NUM_REQ`: request pending, one bit per requester.
- `req_ready  out  NUM_REQ`: one-hot grant; a handshake completes on `req_valid[i] & req_ready[i]`.
- `req_bcd  in  8*NUM_REQ`: requester i uses bits [8i+7:8i]; the upper nibble is tens and the lower nibble is units.
- `rsp_valid  out  NUM_REQ`: one-cycle one-hot response pulse.
- `rsp_bin  out  7`: converted value; valid only while `rsp_valid` is non-zero.
- `rsp_err  out  1`: response is an error (timeout, or a bad digit when checking is compiled in).
- `conv_start  out  1`: start pulse to the converter.
- `conv_bcd1  out  4`, `conv_bcd0  out  4`: tens and units digits to the converter.
- `conv_ready  in  1`: converter is idle and can accept `conv_start`.
- `conv_done_tick  in  1`: one-cycle completion strobe from the converter.
- `conv_bin  in  7`: converter result, valid with `conv_done_tick`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` is one-hot on the first asserted `req_valid` found searching from `rr_ptr` upward, with wrap-around.
  - `req_ready` is all zeros when no request is pending or the state is not IDLE.
  - `req_ready` is combinational from `req_valid` and the state.
  - On a handshake, latch the BCD byte and the requester index, then go to ISSUE.
- **ISSUE**
  - Hold `conv_bcd1`/`conv_bcd0` from the latched byte.
  - Assert `conv_start` for exactly one cycle, in the first ISSUE cycle where `conv_ready`=1.
  - Then go to WAIT and clear the watchdog.
- **WAIT**
  - The watchdog increments every cycle.
  - On `conv_done_tick`: capture `conv_bin`, set `rsp_err`=0, go to RESP.
  - If the watchdog reaches `TIMEOUT` first: set `rsp_bin`=0 and `rsp_err`=1, go to RESP.
- **RESP**
  - Drive `rsp_valid[idx]`=1 for one cycle.
  - Update `rr_ptr` to (idx+1) mod `NUM_REQ`.
  - Return to IDLE.
- `conv_done_tick` in any state other than WAIT is ignored, including a late tick after a timeout.
- `conv_bcd1`/`conv_bcd0` hold their last values outside ISSUE/WAIT; they are never x after reset.
- Requesters must hold `req_bcd` stable until the handshake. Dropping `req_valid` before the grant is legal.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_bin`=0, `rsp_err`=0, `conv_start`=0, `conv_bcd1`=0, `conv_bcd0`=0, watchdog 0.
- Handshake at cycle t. `conv_start` earliest at t+1. Response at d+1, where d is the `conv_done_tick` cycle. IDLE (next grant possible) at d+2.
- If `conv_ready`=0, ISSUE stalls indefinitely; the watchdog runs only in WAIT.
- A timeout response appears at t+2+`TIMEOUT` when `conv_ready` is high at t+1.
- Asserting `reset_n` mid-transaction aborts immediately: no response is issued, and a pending request must be re-presented.
- Simultaneous requests: exactly one grant per transaction, so at most one grant every 4 cycles.
- No requester starves: it is served within `NUM_REQ` transactions.

## Configuration
- `BCD2BIN_ARB_CHECK_EN` defined:
  - At the handshake, a byte with either nibble > 9 skips the converter.
  - FSM goes IDLE → RESP directly, with `rsp_err`=1 and `rsp_bin`=0; the response arrives at t+1.
- Undefined: every byte is forwarded to the converter unchanged, and `rsp_err` is set only on timeout.

## Structure
- Package `bcd2bin_arbiter_pkg` holds:
  - the FSM state enum;
  - the digit limit constant (9);
  - the result width constant (7);
  - the watchdog width constant (8).
- One sub-module, `rr_pick`: combinational round-robin one-hot selector (request vector plus pointer in, grant vector out), reusable by other arbiters.

## Test plan
- Single request from requester 0 with 0x99, converter done 7 cycles after start → `rsp_valid`=0001, `rsp_bin`=0x63, `rsp_err`=0; then 0x55 → 0x37 and 0x90 → 0x5a.
- All four requesters valid at once with 0x00, 0x09, 0x55, 0x99 → grants in order 0,1,2,3; responses 0x00, 0x09, 0x37, 0x63 with matching one-hot `rsp_valid`.
- Requester 2 valid continuously while requester 1 issues once → after requester 1 is served, `rr_ptr`=2 and requester 2 wins next; no starvation over 20 transactions.
- Converter never asserts `conv_done_tick`, `TIMEOUT`=16 → `rsp_err`=1, `rsp_bin`=0 at handshake+18; a late tick afterwards produces no response.
- `reset_n` pulled low during WAIT → all outputs at reset values asynchronously; after release, a new request for 0x42 returns 0x2a.
- With `BCD2BIN_ARB_CHECK_EN`, request 0xA3 → `rsp_err`=1 at handshake+1 and `conv_start` never asserted; without the macro, the same request reaches the converter.
